// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline execute stage.
//   - ALUop encodings driven by decode
//   - write-back select encodings carried to the memory/write-back stages
//   - execute-stage multiply/divide sequencer state encoding
//   - EX/MEM control bundle and its bubble value
package pipe_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIVU = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_NPC = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_w;
        logic mem_r;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_BUBBLE = 3'b000;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / divide, one bit per clock.
//   MUL  : shift-add, low XLEN bits of A*B
//   DIVU : restoring divide, quotient  (B==0 gives all-ones)
//   REMU : restoring divide, remainder (B==0 gives A)
// A start pulse latches op/A/B; MD_CYCLES iterations follow, after which
// done stays high and result holds until the next start. One bit is
// retired per iteration, so MD_CYCLES is expected to equal XLEN.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         latch operands and begin
//   op            ALUop (MUL / DIVU / REMU)
//   A, B          operands
//   busy          iterating
//   done          result valid
//   result        product, quotient or remainder
module muldiv_iter
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 1);

    logic            r_busy;
    logic            r_done;
    logic            r_mul;
    logic            r_quot;
    logic [CW-1:0]   r_cnt;
    // MUL: r_acc product, r_q multiplicand (shifts left), r_b multiplier (shifts right)
    // DIV: r_acc partial remainder, r_q dividend becoming quotient, r_b divisor
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_b;

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;

    assign w_rem_sh = {r_acc, r_q[XLEN-1]};
    // Top bit set means the trial subtraction borrowed: keep the shifted remainder.
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_mul  <= 1'b0;
            r_quot <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_b    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_mul  <= (op == ALU_MUL);
            r_quot <= (op == ALU_DIVU);
            r_cnt  <= CNT_LOAD;
            r_acc  <= '0;
            r_q    <= A;
            r_b    <= B;
        end else if (r_busy) begin
            if (r_mul) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_q;
                end
                r_q <= r_q << 1;
                r_b <= r_b >> 1;
            end else if (!w_diff[XLEN]) begin
                r_acc <= w_diff[XLEN-1:0];
                r_q   <= {r_q[XLEN-2:0], 1'b1};
            end else begin
                r_acc <= w_rem_sh[XLEN-1:0];
                r_q   <= {r_q[XLEN-2:0], 1'b0};
            end
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_quot ? r_q : r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, multiply/divide handshake and the
// EX/MEM pipeline register feeding the memory stage.
//
// Build option EX_MULDIV_EN:
//   defined   - ALUop MUL/DIVU/REMU run through muldiv_iter; upstream is
//               stalled until the result is written
//   undefined - those ops finish in one cycle with result 0, no sequencer,
//               stall_out tied low
//
// States (EX_MULDIV_EN only):
//   state | meaning
//   IDLE  | single-cycle ops flow; a valid mul/div op stalls and starts the unit
//   BUSY  | unit iterating, counter counts 0..MD_CYCLES-1, bubbles loaded
//   DONE  | result ready, written to EX/MEM on this edge, stall released
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   valid_in, flush                instruction valid, kill instruction in EX
//   ALUop, A, B                    operation and operands
//   D_in, NPC_in, rd_in            store data, PC+4, destination register
//   RegWrite_in, memW_in, memR_in  controls from decode
//   WBdata_in                      write-back select
//   stall_out                      hold PC, IF/ID and ID/EX
//   RegWrite_EX, memW, memR        registered controls
//   WBdata, ALUout, D, NPC3, rd3   registered data fields
module ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [3:0]      ALUop,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] D_in,
    input  logic [XLEN-1:0] NPC_in,
    input  logic [4:0]      rd_in,
    input  logic            RegWrite_in,
    input  logic            memW_in,
    input  logic            memR_in,
    input  logic [1:0]      WBdata_in,
    output logic            stall_out,
    output logic            RegWrite_EX,
    output logic            memW,
    output logic            memR,
    output logic [1:0]      WBdata,
    output logic [XLEN-1:0] ALUout,
    output logic [XLEN-1:0] D,
    output logic [XLEN-1:0] NPC3,
    output logic [4:0]      rd3
);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_res;
    logic            w_stall;
    mem_ctrl_t       w_ctrl;

    mem_ctrl_t       r_ctrl;
    logic [1:0]      r_wbdata;
    logic [XLEN-1:0] r_aluout;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_npc;
    logic [4:0]      r_rd;

    assign w_shamt = B[4:0];

    // MUL/DIVU/REMU and the unused codes fall to the default of 0.
    always_comb begin
        w_alu = '0;
        case (ALUop)
            ALU_ADD:  w_alu = A + B;
            ALU_SUB:  w_alu = A - B;
            ALU_AND:  w_alu = A & B;
            ALU_OR:   w_alu = A | B;
            ALU_XOR:  w_alu = A ^ B;
            ALU_SLL:  w_alu = A << w_shamt;
            ALU_SRL:  w_alu = A >> w_shamt;
            ALU_SRA:  w_alu = $signed(A) >>> w_shamt;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (A < B)};
            default:  w_alu = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

    ex_state_e       r_state;
    ex_state_e       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_start;
    logic            w_md_busy;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_in && !flush && is_muldiv(ALUop)) begin
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gated by reset so upstream is released as soon as rst_n falls.
    assign stall_out = rst_n & w_stall;

    muldiv_iter #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .op     (ALUop),
        .A      (A),
        .B      (B),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_comb begin
        w_res              = w_alu;
        w_ctrl.reg_write   = RegWrite_in;
        w_ctrl.mem_w       = memW_in;
        w_ctrl.mem_r       = memR_in;
        if (r_state == ST_DONE) begin
            w_res = w_md_result;
            if (!w_md_done || w_md_busy) begin
                w_ctrl = CTRL_BUBBLE;
            end
        end
        if (flush || !valid_in || w_stall) begin
            w_ctrl = CTRL_BUBBLE;
        end
    end
`else
    assign w_stall   = 1'b0;
    assign stall_out = w_stall;

    always_comb begin
        w_res            = w_alu;
        w_ctrl.reg_write = RegWrite_in;
        w_ctrl.mem_w     = memW_in;
        w_ctrl.mem_r     = memR_in;
        if (flush || !valid_in || w_stall) begin
            w_ctrl = CTRL_BUBBLE;
        end
    end
`endif

    // Data fields are loaded even for bubbles; only the controls matter then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl   <= CTRL_BUBBLE;
            r_wbdata <= WB_ALU;
            r_aluout <= '0;
            r_d      <= '0;
            r_npc    <= '0;
            r_rd     <= '0;
        end else begin
            r_ctrl   <= w_ctrl;
            r_wbdata <= WBdata_in;
            r_aluout <= w_res;
            r_d      <= D_in;
            r_npc    <= NPC_in;
            r_rd     <= rd_in;
        end
    end

    assign RegWrite_EX = r_ctrl.reg_write;
    assign memW        = r_ctrl.mem_w;
    assign memR        = r_ctrl.mem_r;
    assign WBdata      = r_wbdata;
    assign ALUout      = r_aluout;
    assign D           = r_d;
    assign NPC3        = r_npc;
    assign rd3         = r_rd;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops
// compared against an arithmetic reference model. Works in both builds
// (EX_MULDIV_EN defined or not).
module tb_ex_stage;

    localparam int XLEN      = 32;
    localparam int MD_CYCLES = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic            flush;
    logic [3:0]      ALUop;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] D_in;
    logic [XLEN-1:0] NPC_in;
    logic [4:0]      rd_in;
    logic            RegWrite_in;
    logic            memW_in;
    logic            memR_in;
    logic [1:0]      WBdata_in;
    logic            stall_out;
    logic            RegWrite_EX;
    logic            memW;
    logic            memR;
    logic [1:0]      WBdata;
    logic [XLEN-1:0] ALUout;
    logic [XLEN-1:0] D;
    logic [XLEN-1:0] NPC3;
    logic [4:0]      rd3;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .flush       (flush),
        .ALUop       (ALUop),
        .A           (A),
        .B           (B),
        .D_in        (D_in),
        .NPC_in      (NPC_in),
        .rd_in       (rd_in),
        .RegWrite_in (RegWrite_in),
        .memW_in     (memW_in),
        .memR_in     (memR_in),
        .WBdata_in   (WBdata_in),
        .stall_out   (stall_out),
        .RegWrite_EX (RegWrite_EX),
        .memW        (memW),
        .memR        (memR),
        .WBdata      (WBdata),
        .ALUout      (ALUout),
        .D           (D),
        .NPC3        (NPC3),
        .rd3         (rd3)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return $unsigned($signed(a) >>> sh);
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
`ifdef EX_MULDIV_EN
            10: return a * b;
            11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            12: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'($urandom_range(0, 40));
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic check_reset(input string pfx);
        check_val({pfx, "_regwrite"}, 32'(RegWrite_EX), 32'd0);
        check_val({pfx, "_memw"},     32'(memW),        32'd0);
        check_val({pfx, "_memr"},     32'(memR),        32'd0);
        check_val({pfx, "_wbdata"},   32'(WBdata),      32'd0);
        check_val({pfx, "_aluout"},   ALUout,           32'd0);
        check_val({pfx, "_d"},        D,                32'd0);
        check_val({pfx, "_npc3"},     NPC3,             32'd0);
        check_val({pfx, "_rd3"},      32'(rd3),         32'd0);
        check_val({pfx, "_stall"},    32'(stall_out),   32'd0);
    endtask

    // Called just after a rising edge; returns just after the edge that
    // writes the instruction's outcome into EX/MEM.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic mr,
                         input logic [1:0] wb, input logic [31:0] d, input logic [31:0] npc,
                         input logic vld, input logic fl);
        logic [31:0] exp;
        logic        live;
        logic        md_path;
        int          n;
        logic        ctrl_seen;
        ALUop = op; A = a; B = b; rd_in = rd;
        RegWrite_in = rw; memW_in = mw; memR_in = mr;
        WBdata_in = wb; D_in = d; NPC_in = npc;
        valid_in = vld; flush = fl;
        exp  = model_alu(int'(op), a, b);
        live = vld && !fl;
        md_path = 1'b0;
`ifdef EX_MULDIV_EN
        md_path = live && (op inside {4'd10, 4'd11, 4'd12});
`endif
        if (md_path) begin
            n = 0;
            ctrl_seen = 1'b0;
            for (int k = 0; k < MD_CYCLES + 4; k++) begin
                @(negedge clk);
                if (!stall_out) break;
                n++;
                @(posedge clk); #1;
                ctrl_seen = ctrl_seen | RegWrite_EX | memW | memR;
            end
            check_val("md_stall_cycles", 32'(n), 32'(MD_CYCLES + 1));
            check_val("md_stall_bubble", 32'(ctrl_seen), 32'd0);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            check_val("no_stall", 32'(stall_out), 32'd0);
            @(posedge clk); #1;
        end
        if (live) begin
            check_val("regwrite", 32'(RegWrite_EX), 32'(rw));
            check_val("memw",     32'(memW),        32'(mw));
            check_val("memr",     32'(memR),        32'(mr));
            check_val("aluout",   ALUout,           exp);
            check_val("rd3",      32'(rd3),         32'(rd));
            check_val("d",        D,                d);
            check_val("npc3",     NPC3,             npc);
            check_val("wbdata",   32'(WBdata),      32'(wb));
        end else begin
            check_val("bubble_regwrite", 32'(RegWrite_EX), 32'd0);
            check_val("bubble_memw",     32'(memW),        32'd0);
            check_val("bubble_memr",     32'(memR),        32'd0);
        end
    endtask

    initial begin
        logic [3:0] rop;
        logic       rfl;
        rst_n = 1'b1;
        valid_in = 1'b0; flush = 1'b0; ALUop = '0; A = '0; B = '0;
        D_in = '0; NPC_in = '0; rd_in = '0;
        RegWrite_in = 1'b0; memW_in = 1'b0; memR_in = 1'b0; WBdata_in = '0;
        #1 rst_n = 1'b0;
        #2 check_reset("rst_init");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(4'd0, 32'hFFFF_FFFF, 32'd2, 5'd5, 1, 0, 0, 2'b00, 32'h0, 32'h10, 1, 0);
        do_op(4'd8, 32'h8000_0000, 32'd1, 5'd6, 1, 0, 0, 2'b00, 32'h0, 32'h14, 1, 0);
        do_op(4'd9, 32'h8000_0000, 32'd1, 5'd7, 1, 0, 0, 2'b00, 32'h0, 32'h18, 1, 0);
        do_op(4'd7, 32'h8000_0000, 32'd4, 5'd8, 1, 0, 0, 2'b00, 32'h0, 32'h1C, 1, 0);
        do_op(4'd10, 32'd7,   32'd6, 5'd9,  1, 0, 0, 2'b00, 32'h0, 32'h20, 1, 0);
        do_op(4'd11, 32'd100, 32'd0, 5'd10, 1, 0, 0, 2'b00, 32'h0, 32'h24, 1, 0);
        do_op(4'd12, 32'd100, 32'd0, 5'd11, 1, 0, 0, 2'b00, 32'h0, 32'h28, 1, 0);
        do_op(4'd0, 32'h100, 32'd8, 5'd0, 0, 1, 0, 2'b01, 32'hDEAD_BEEF, 32'h104, 1, 0);
        do_op(4'd0, 32'd1, 32'd1, 5'd3, 1, 1, 1, 2'b10, 32'h1, 32'h2, 0, 0);
        do_op(4'd0, 32'd1, 32'd1, 5'd3, 1, 1, 1, 2'b10, 32'h1, 32'h2, 1, 1);
        do_op(4'd13, 32'h1234, 32'h5678, 5'd4, 1, 0, 0, 2'b00, 32'h0, 32'h30, 1, 0);

`ifdef EX_MULDIV_EN
        // Flush ten cycles into a divide
        ALUop = 4'd11; A = 32'd1000; B = 32'd7; rd_in = 5'd12;
        RegWrite_in = 1'b1; memW_in = 1'b0; memR_in = 1'b0;
        valid_in = 1'b1; flush = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_busy_stall", 32'(stall_out), 32'd1);
        @(posedge clk); #1;
        check_val("flush_bubble", 32'(RegWrite_EX), 32'd0);
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check_val("flush_stall_drop", 32'(stall_out), 32'd0);
        @(posedge clk); #1;
        do_op(4'd0, 32'd40, 32'd2, 5'd13, 1, 0, 0, 2'b00, 32'h0, 32'h40, 1, 0);
        do_op(4'd11, 32'd1000, 32'd7, 5'd14, 1, 0, 0, 2'b00, 32'h0, 32'h44, 1, 0);
`endif

        // Reset in the middle of a multiply
        do_op(4'd0, 32'd5, 32'd6, 5'd9, 1, 0, 1, 2'b10, 32'h55, 32'h200, 1, 0);
        ALUop = 4'd10; A = 32'd3; B = 32'd9; valid_in = 1'b1; flush = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        valid_in = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'd1, 32'd5, 32'd9, 5'd15, 1, 0, 0, 2'b00, 32'h0, 32'h300, 1, 0);

        // Randomized ops
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            rfl = ($urandom_range(0, 9) == 0);
            if (rop inside {4'd10, 4'd11, 4'd12}) rfl = 1'b0;
            do_op(rop, rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 2)), $urandom(), $urandom(),
                  ($urandom_range(0, 7) != 0), rfl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
